// File: rtl/led_scan_drv.sv
// Multiplexed LED matrix driver: accumulates LED requests over a scan frame,
// then scans the snapshot row by row with inter-row blanking and global PWM.

module led_scan_col (
  input  logic CK_i,
  input  logic RST_i,
  input  logic drive,
  output logic xcol
);
  always_ff @(posedge CK_i) begin
    if (RST_i) xcol <= 1'b1;
    else       xcol <= ~drive;
  end
endmodule

module led_scan_drv #(
  parameter int C_ROW_N    = 3,
  parameter int C_COL_N    = 6,
  parameter int C_SCAN_DIV = 4096,
  parameter int C_BLANK_N  = 64,
  parameter int C_PWM_W    = 4
) (
  input  logic                       CK_i,
  input  logic                       RST_i,
  input  logic [C_ROW_N*C_COL_N-1:0] LEDs_ON_i,
  input  logic [C_PWM_W-1:0]         BRIGHT_i,
  output logic [C_ROW_N-1:0]         ROWs_o,
  output logic [C_COL_N-1:0]         XCOLs_o,
  output logic                       FRAME_o
);
  localparam int SLOT_W = (C_SCAN_DIV > 1) ? $clog2(C_SCAN_DIV) : 1;
  localparam int ROW_W  = (C_ROW_N > 1) ? $clog2(C_ROW_N) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(C_SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(C_BLANK_N);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(C_ROW_N - 1);

  logic [SLOT_W-1:0] slot_q;
  logic [ROW_W-1:0]  row_q;
  logic [C_ROW_N*C_COL_N-1:0]       acc_q;
  logic [C_ROW_N-1:0][C_COL_N-1:0] disp_q;

  logic slot_last, row_last, fe, act, pwm;
  logic [C_COL_N-1:0] disp_row;

  assign slot_last = (slot_q == SLOT_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign fe        = slot_last & row_last;
  assign act       = (slot_q >= BLANK_END);
  assign pwm       = (slot_q[C_PWM_W-1:0] <= BRIGHT_i);
  assign disp_row  = disp_q[row_q];

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      slot_q <= '0;
      row_q  <= '0;
    end else if (slot_last) begin
      slot_q <= '0;
      row_q  <= row_last ? '0 : row_q + 1'b1;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // The FE-cycle sample lands directly in the display buffer so that a
  // request coinciding with frame end is not lost or delayed a frame.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      acc_q  <= '0;
      disp_q <= '0;
    end else if (fe) begin
      disp_q <= acc_q | LEDs_ON_i;
      acc_q  <= '0;
    end else begin
      acc_q  <= acc_q | LEDs_ON_i;
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      ROWs_o  <= '0;
      FRAME_o <= 1'b0;
    end else begin
      ROWs_o  <= act ? (C_ROW_N'(1) << row_q) : '0;
      FRAME_o <= fe;
    end
  end

  for (genvar c = 0; c < C_COL_N; c++) begin : g_col
    led_scan_col u_col (
      .CK_i  (CK_i),
      .RST_i (RST_i),
      .drive (act & pwm & disp_row[c]),
      .xcol  (XCOLs_o[c])
    );
  end
endmodule

// File: doc/led_scan_drv.md
# led_scan_drv

Multiplexed LED matrix driver for the game cores' LED vector (LEDs_ON_o of the Planet Empire core and similar). It accumulates the LED request vector over one scan frame, so that short pulses such as missile steps are never missed. It then scans the snapshot row by row onto a row/column matrix with inter-row blanking and global PWM brightness. The block sits between the game core and the board pins, replacing one-pin-per-LED wiring.

## Interface
- C_ROW_N, 3, matrix rows (row anodes).
- C_COL_N, 6, matrix columns (column cathodes); LED index k = row*C_COL_N + col.
- C_SCAN_DIV, 4096, clocks per row slot; must be > C_BLANK_N and >= 2**C_PWM_W.
- C_BLANK_N, 64, blanking clocks at start of each slot (ghosting suppression).
- C_PWM_W, 4, brightness width.

Ports:
- CK_i  in  1  system clock.
- RST_i  in  1  reset; one clock; reset is synchronous and active-high.
- LEDs_ON_i  in  C_ROW_N*C_COL_N  LED requests, 1 = lit; asynchronous to the scan, sampled every clock.
- BRIGHT_i  in  C_PWM_W  global brightness; duty = (BRIGHT_i+1)/2**C_PWM_W; sampled live, not snapshotted.
- ROWs_o  out  C_ROW_N  row enables, one-hot active-high, 0 during blanking.
- XCOLs_o  out  C_COL_N  column sinks, active-low.
- FRAME_o  out  1  one-clock pulse in the first cycle of each frame.

## Operation
- Counters:
  - SLOT counts 0..C_SCAN_DIV-1 and wraps to 0.
  - ROW counts 0..C_ROW_N-1 and increments only on a SLOT wrap; ROW wraps to 0.
  - Frame end (FE) is SLOT==C_SCAN_DIV-1 and ROW==C_ROW_N-1.
  - A frame is C_ROW_N*C_SCAN_DIV clocks.
- Accumulator ACC:
  - Each clock, ACC <= ACC | LEDs_ON_i.
  - On FE: BUF <= ACC | LEDs_ON_i and ACC <= 0.
  - Any request bit high for ≥1 clock in frame N is displayed for all of frame N+1. If it is low throughout frame N+1, it is dark in frame N+2.
- Display: BUF is constant for a whole frame, so there is no tearing.
- Output registers, computed from the pre-edge SLOT, ROW and BUF:
  - act = (SLOT >= C_BLANK_N).
  - pwm = (SLOT[C_PWM_W-1:0] <= BRIGHT_i).
  - ROWs_o <= act ? (1<<ROW) : 0.
  - XCOLs_o[c] <= ~(act & pwm & BUF[ROW*C_COL_N+c]).
  - FRAME_o <= FE.
- Rows and columns are never driven during blanking, so a row switch always has ≥C_BLANK_N dark clocks.
- No state machine beyond the SLOT/ROW counters; the ACC/BUF double buffer is the only storage.

## Timing
- Reset (RST_i high at an edge) sets:
  - SLOT=0, ROW=0, ACC=0, BUF=0.
  - ROWs_o=0, XCOLs_o=all ones, FRAME_o=0.
- All outputs are registered; they are valid one clock after the counter state they reflect.
- First frame after reset displays BUF=0, i.e. all columns off. Rows still scan.
- FRAME_o goes high first at the (C_ROW_N*C_SCAN_DIV)-th edge after reset release, then every frame period. That cycle shows the SLOT=0/ROW=0 blanking state.
- Input-to-pin latency: 1 to 2 frames plus 1 clock.
- Simultaneous LEDs_ON_i edge and FE: the FE-cycle sample goes into BUF, not ACC.
- RST_i mid-frame: reset values on the next clock. BUF and ACC are cleared, so the pattern is dark for one full frame after release.
- BRIGHT_i change takes effect on the next clock.
- At BRIGHT_i = all ones, columns are continuously on during the active window.

## Test plan
Bench parameters: C_ROW_N=3, C_COL_N=6, C_SCAN_DIV=16, C_BLANK_N=2, C_PWM_W=2; frame = 48 clocks.

- **Reset:** RST_i high 3 clocks -> ROWs_o=3'b000, XCOLs_o=6'h3F, FRAME_o=0. After release, FRAME_o is high exactly at clocks 48, 96, 144, with no other pulses.
- **Static pattern:** LEDs_ON_i=18'h00001, BRIGHT_i=3.
  - From the second frame, in the row-0 slot at SLOT 2..15 (+1 clock): ROWs_o=3'b001, XCOLs_o=6'b111110.
  - At SLOT 0..1: ROWs_o=0, XCOLs_o=6'h3F.
  - Rows 1 and 2: XCOLs_o=6'h3F.
- **Pulse capture:** LEDs_ON_i[17] high for a single clock at SLOT 5, ROW 1 -> next frame, row-2 slot shows XCOLs_o=6'b011111 for all active clocks. The frame after that is all 6'h3F.
- **Brightness:** LEDs_ON_i=18'h3FFFF.
  - BRIGHT_i=0 -> XCOLs_o=6'h00 only one clock after SLOT 4, 8, 12 in each slot; 6'h3F otherwise.
  - BRIGHT_i=1 -> low for SLOT[1:0] in {0,1} within SLOT ≥2.
  - BRIGHT_i=3 -> low for all of SLOT 2..15.
- **Mid-frame reset:** with the static pattern displayed, assert RST_i at SLOT 7, ROW 1 -> reset output values next clock. After release, frame 1 is all 6'h3F and the pattern returns in frame 2.
